// File: rtl/jk_excitation_driver_if.sv
// Target handshake plus the j/k/q connection to the downstream JK flop.
// The driver uses the master modport; the source/flop side uses slave.
interface jk_excitation_driver_if;
    logic tgt_valid;
    logic tgt_bit;
    logic tgt_ready;
    logic j;
    logic k;
    logic q;

    modport master (
        input  tgt_valid,
        input  tgt_bit,
        input  q,
        output tgt_ready,
        output j,
        output k
    );

    modport slave (
        output tgt_valid,
        output tgt_bit,
        output q,
        input  tgt_ready,
        input  j,
        input  k
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives a JK flop towards a stream of requested target bits: converts each
// target into the JK excitation code for one clock, then checks q two edges
// after the handshake and keeps saturating done/error counters.
module jk_excitation_driver #(
    parameter int unsigned CNT_W      = 8,
    parameter bit          USE_TOGGLE = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    jk_excitation_driver_if.master bus,
    input  logic                   clr_cnt,
    output logic                   busy,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       done_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StDrive,
        StCheck
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             tgt_ready_q, tgt_ready_d;
    logic             busy_q, busy_d;
    logic             err_pulse_q, err_pulse_d;
    logic             tgt_q, tgt_d;
    logic             q_prev_q, q_prev_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             done_inc;
    logic             err_inc;

    // State register; async reset drops j/k at once and discards any transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StInit;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            tgt_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            tgt_q       <= 1'b0;
            q_prev_q    <= 1'b0;
            done_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            k_q         <= k_d;
            tgt_ready_q <= tgt_ready_d;
            busy_q      <= busy_d;
            err_pulse_q <= err_pulse_d;
            tgt_q       <= tgt_d;
            q_prev_q    <= q_prev_d;
            done_cnt_q  <= done_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state, excitation and check logic; j/k default to 0 outside DRIVE.
    always_comb begin
        state_d     = state_q;
        j_d         = 1'b0;
        k_d         = 1'b0;
        tgt_ready_d = tgt_ready_q;
        busy_d      = busy_q;
        err_pulse_d = 1'b0;
        tgt_d       = tgt_q;
        q_prev_d    = q_prev_q;
        done_inc    = 1'b0;
        err_inc     = 1'b0;

        unique case (state_q)
            StInit: begin
                state_d     = StIdle;
                tgt_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            StIdle: begin
                tgt_ready_d = 1'b1;
                if (bus.tgt_valid && tgt_ready_q) begin
                    tgt_d    = bus.tgt_bit;
                    q_prev_d = bus.q;
                    // Only a change of state needs a non-zero code.
                    if (bus.q != bus.tgt_bit) begin
                        if (USE_TOGGLE) begin
                            j_d = 1'b1;
                            k_d = 1'b1;
                        end else begin
                            j_d = bus.tgt_bit;
                            k_d = ~bus.tgt_bit;
                        end
                    end
                    tgt_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = StDrive;
                end
            end
            StDrive: begin
                // The flop samples j/k on this edge.
                state_d = StCheck;
            end
            StCheck: begin
                done_inc = 1'b1;
                if (bus.q != tgt_q) begin
                    err_inc     = 1'b1;
                    err_pulse_d = 1'b1;
                end
                tgt_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Saturating counters; a clear overrides a coincident increment.
        done_cnt_d = done_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clr_cnt) begin
            done_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            if (done_inc && (done_cnt_q != CntMax)) begin
                done_cnt_d = done_cnt_q + 1'b1;
            end
            if (err_inc && (err_cnt_q != CntMax)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.tgt_ready = tgt_ready_q;
    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign busy          = busy_q;
    assign err_pulse     = err_pulse_q;
    assign done_cnt      = done_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: three drivers (set/reset, toggle, 2-bit counters with the
// flop held in reset) share one target stream, each with its own JK flop.
module tb_jk_excitation_driver;

    logic clk = 1'b0;
    logic rst;
    logic tv;
    logic tbit;
    logic clr;
    logic fr0, fr1, fr2;
    logic q0, q1, q2;

    logic       busy0, busy1, busy2;
    logic       ep0, ep1, ep2;
    logic [7:0] done0, err0, done1, err1;
    logic [1:0] done2, err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_excitation_driver_if bus0 ();
    jk_excitation_driver_if bus1 ();
    jk_excitation_driver_if bus2 ();

    assign bus0.tgt_valid = tv;
    assign bus0.tgt_bit   = tbit;
    assign bus0.q         = q0;
    assign bus1.tgt_valid = tv;
    assign bus1.tgt_bit   = tbit;
    assign bus1.q         = q1;
    assign bus2.tgt_valid = tv;
    assign bus2.tgt_bit   = tbit;
    assign bus2.q         = q2;

    jk_excitation_driver #(.CNT_W(8), .USE_TOGGLE(1'b0)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0), .clr_cnt(clr),
        .busy(busy0), .err_pulse(ep0), .done_cnt(done0), .err_cnt(err0)
    );

    jk_excitation_driver #(.CNT_W(8), .USE_TOGGLE(1'b1)) dut1 (
        .clk(clk), .reset(rst), .bus(bus1), .clr_cnt(clr),
        .busy(busy1), .err_pulse(ep1), .done_cnt(done1), .err_cnt(err1)
    );

    jk_excitation_driver #(.CNT_W(2), .USE_TOGGLE(1'b0)) dut2 (
        .clk(clk), .reset(rst), .bus(bus2), .clr_cnt(clr),
        .busy(busy2), .err_pulse(ep2), .done_cnt(done2), .err_cnt(err2)
    );

    // Behavioural JK flops on the same clock, each with its own reset.
    always @(posedge clk or posedge fr0) begin
        if (fr0) q0 <= 1'b0;
        else case ({bus0.j, bus0.k})
            2'b01:   q0 <= 1'b0;
            2'b10:   q0 <= 1'b1;
            2'b11:   q0 <= ~q0;
            default: q0 <= q0;
        endcase
    end

    always @(posedge clk or posedge fr1) begin
        if (fr1) q1 <= 1'b0;
        else case ({bus1.j, bus1.k})
            2'b01:   q1 <= 1'b0;
            2'b10:   q1 <= 1'b1;
            2'b11:   q1 <= ~q1;
            default: q1 <= q1;
        endcase
    end

    always @(posedge clk or posedge fr2) begin
        if (fr2) q2 <= 1'b0;
        else case ({bus2.j, bus2.k})
            2'b01:   q2 <= 1'b0;
            2'b10:   q2 <= 1'b1;
            2'b11:   q2 <= ~q2;
            default: q2 <= q2;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transfer of bit b; expected values are supplied by the caller.
    task automatic send(input logic b, input logic [1:0] jk0, input logic [1:0] jk1,
                        input int d0, input int e0, input int d2, input int e2,
                        input logic clr_at_check);
        tv   = 1'b1;
        tbit = b;
        check("ready_before_accept", 8'(bus0.tgt_ready), 8'd1);
        tick;  // E0
        tv = 1'b0;
        check("jk_setreset", 8'({bus0.j, bus0.k}), 8'(jk0));
        check("jk_toggle", 8'({bus1.j, bus1.k}), 8'(jk1));
        check("busy_drive", 8'(busy0), 8'd1);
        check("ready_drive", 8'(bus0.tgt_ready), 8'd0);
        check("err_pulse_one_cycle", 8'(ep2), 8'd0);
        tick;  // E1
        check("jk_zero_check", 8'({bus0.j, bus0.k, bus1.j, bus1.k}), 8'd0);
        check("ready_check", 8'(bus0.tgt_ready), 8'd0);
        check("q_setreset", 8'(q0), 8'(b));
        check("q_toggle", 8'(q1), 8'(b));
        clr = clr_at_check;
        tick;  // E2
        clr = 1'b0;
        check("err_pulse_match", 8'(ep0), 8'd0);
        check("err_pulse_stuck", 8'(ep2), 8'(b));
        check("ready_idle", 8'(bus0.tgt_ready), 8'd1);
        check("busy_idle", 8'(busy0), 8'd0);
        check("done_cnt0", done0, 8'(d0));
        check("err_cnt0", err0, 8'(e0));
        check("done_cnt2", 8'(done2), 8'(d2));
        check("err_cnt2", 8'(err2), 8'(e2));
    endtask

    initial begin
        logic [0:5] pat;
        rst  = 1'b1;
        fr0  = 1'b1;
        fr1  = 1'b1;
        fr2  = 1'b1;
        tv   = 1'b0;
        tbit = 1'b0;
        clr  = 1'b0;
        tick;
        tick;
        check("rst_jk", 8'({bus0.j, bus0.k}), 8'd0);
        check("rst_ready", 8'(bus0.tgt_ready), 8'd0);
        check("rst_busy", 8'(busy0), 8'd0);
        check("rst_err_pulse", 8'(ep0), 8'd0);
        check("rst_done", done0, 8'd0);
        check("rst_err", err0, 8'd0);

        rst = 1'b0;
        fr0 = 1'b0;
        fr1 = 1'b0;
        check("ready_after_release", 8'(bus0.tgt_ready), 8'd0);
        tick;
        check("ready_init_to_idle", 8'(bus0.tgt_ready), 8'd1);

        // Set/reset and toggle sequence 1,0,0,1; dut2's flop is stuck at 0.
        send(1'b1, 2'b10, 2'b11, 1, 0, 1, 1, 1'b0);
        send(1'b0, 2'b01, 2'b11, 2, 0, 2, 1, 1'b0);
        send(1'b0, 2'b00, 2'b00, 3, 0, 3, 1, 1'b0);
        send(1'b1, 2'b10, 2'b11, 4, 0, 3, 2, 1'b0);
        // More mismatches on dut2: error counter saturates at 3.
        send(1'b1, 2'b00, 2'b00, 5, 0, 3, 3, 1'b0);
        send(1'b1, 2'b00, 2'b00, 6, 0, 3, 3, 1'b0);
        send(1'b1, 2'b00, 2'b00, 7, 0, 3, 3, 1'b0);
        check("toggle_err_cnt", err1, 8'd0);
        check("toggle_done_cnt", done1, 8'd7);
        // Clear coinciding with a CHECK increment: clear wins.
        send(1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1);

        // Back-to-back: valid held for 6 cycles gives two accepts.
        pat  = 6'b100100;
        tv   = 1'b1;
        tbit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("b2b_ready", 8'(bus0.tgt_ready), 8'(pat[i]));
            tick;
        end
        tv = 1'b0;
        check("b2b_done", done0, 8'd2);
        check("b2b_q", 8'(q0), 8'd0);

        // Reset in the middle of DRIVE with j asserted.
        tv   = 1'b1;
        tbit = 1'b1;
        tick;
        tv = 1'b0;
        check("mid_drive_jk", 8'({bus0.j, bus0.k}), 8'b10);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_jk", 8'({bus0.j, bus0.k}), 8'd0);
        check("async_rst_ready", 8'(bus0.tgt_ready), 8'd0);
        check("async_rst_busy", 8'(busy0), 8'd0);
        check("async_rst_done", done0, 8'd0);
        tick;
        rst = 1'b0;
        check("rerelease_ready", 8'(bus0.tgt_ready), 8'd0);
        tick;
        check("rerelease_ready_idle", 8'(bus0.tgt_ready), 8'd1);
        check("rerelease_done", done0, 8'd0);
        check("rerelease_err", err0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
